// File: rtl/bit_code_gen.sv
// Pulse-width serial bit encoder (WS2812-style) fed by a valid/ready bit stream.
// Optional macro BIT_CODE_INV_EN inverts bit_code_o (idle/reset level becomes 1).
module bit_code_gen #(
  parameter int unsigned HIGH_W   = 8,
  parameter int unsigned PERIOD_W = 9
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                bit_vld_i,
  input  logic                bit_data_i,
  input  logic [HIGH_W-1:0]   reg_t0h_time_i,
  input  logic [PERIOD_W-1:0] reg_t0s_time_i,
  input  logic [HIGH_W-1:0]   reg_t1h_time_i,
  input  logic [PERIOD_W-1:0] reg_t1s_time_i,
  output logic                bit_rdy_o,
  output logic                bit_code_o
);

`ifdef BIT_CODE_INV_EN
  localparam logic CODE_INV = 1'b1;
`else
  localparam logic CODE_INV = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t              state, state_nx;
  logic [PERIOD_W-1:0] cnt, cnt_nx;
  logic [PERIOD_W-1:0] last, last_nx;
  logic [PERIOD_W-1:0] high, high_nx;
  logic [PERIOD_W-1:0] sel_s, sel_h, per, hi;
  logic                code_nx, rdy_nx, accept;

  assign accept = bit_vld_i && bit_rdy_o;

  // Effective timing of the candidate bit: P = max(ts,1), H = min(th,P).
  always_comb begin
    sel_s = bit_data_i ? reg_t1s_time_i : reg_t0s_time_i;
    sel_h = bit_data_i ? PERIOD_W'(reg_t1h_time_i) : PERIOD_W'(reg_t0h_time_i);
    per   = (sel_s == '0) ? PERIOD_W'(1) : sel_s;
    hi    = (sel_h > per) ? per : sel_h;
  end

  // Outputs are registered from the next counter value, so they describe the
  // cycle that follows the edge; this gives the 1-clock accept latency.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    last_nx  = last;
    high_nx  = high;
    code_nx  = 1'b0;
    rdy_nx   = 1'b0;
    if (accept) begin
      cnt_nx   = '0;
      last_nx  = per - PERIOD_W'(1);
      high_nx  = hi;
      code_nx  = (hi != '0);
      state_nx = code_nx ? HIGH : LOW;
      rdy_nx   = (per == PERIOD_W'(1));
    end else begin
      case (state)
        IDLE: rdy_nx = 1'b1;
        HIGH, LOW: begin
          if (cnt == last) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            rdy_nx   = 1'b1;
          end else begin
            cnt_nx   = cnt + PERIOD_W'(1);
            code_nx  = (cnt_nx < high);
            state_nx = code_nx ? HIGH : LOW;
            rdy_nx   = (cnt_nx == last);
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      last       <= '0;
      high       <= '0;
      bit_rdy_o  <= 1'b0;
      bit_code_o <= CODE_INV;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      last       <= last_nx;
      high       <= high_nx;
      bit_rdy_o  <= rdy_nx;
      bit_code_o <= code_nx ^ CODE_INV;
    end
  end

endmodule

// File: tb/tb_bit_code_gen.sv
// Self-checking bench for bit_code_gen: a queue of expected line levels per cycle.
module tb_bit_code_gen;

`ifdef BIT_CODE_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       bit_vld_i = 1'b0;
  logic       bit_data_i = 1'b0;
  logic [7:0] reg_t0h_time_i = '0;
  logic [8:0] reg_t0s_time_i = '0;
  logic [7:0] reg_t1h_time_i = '0;
  logic [8:0] reg_t1s_time_i = '0;
  logic       bit_rdy_o;
  logic       bit_code_o;

  int unsigned errors = 0;
  int unsigned checks = 0;

  bit q[$];
  bit started = 1'b0;

  bit_code_gen #(.HIGH_W(8), .PERIOD_W(9)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bit_vld_i(bit_vld_i), .bit_data_i(bit_data_i),
    .reg_t0h_time_i(reg_t0h_time_i), .reg_t0s_time_i(reg_t0s_time_i),
    .reg_t1h_time_i(reg_t1h_time_i), .reg_t1s_time_i(reg_t1s_time_i),
    .bit_rdy_o(bit_rdy_o), .bit_code_o(bit_code_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit m_rdy();
    return started && (q.size() <= 1);
  endfunction

  function automatic bit m_code();
    return (q.size() == 0) ? INV : (q[0] ^ INV);
  endfunction

  // Advance the reference by one clock edge, then settle 1 time unit after it.
  task automatic tick();
    int xh, xs, p, h;
    bit acc;
    @(posedge clk_i);
    if (rst_i) begin
      q.delete();
      started = 1'b0;
    end else begin
      acc = started && bit_vld_i && (q.size() <= 1);
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        xh = bit_data_i ? int'(reg_t1h_time_i) : int'(reg_t0h_time_i);
        xs = bit_data_i ? int'(reg_t1s_time_i) : int'(reg_t0s_time_i);
        p  = (xs == 0) ? 1 : xs;
        h  = (xh < p) ? xh : p;
        for (int i = 0; i < p; i++) q.push_back(i < h);
      end
      started = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    checks++;
    if (bit_code_o !== INV || bit_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold code=%b exp=%b rdy=%b exp=0", bit_code_o, INV, bit_rdy_o);
    end
    rst_i = 1'b0;
    #1;
    checks++;
    if (bit_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_rdy rdy=%b exp=0", bit_rdy_o);
    end
    tick();
    checks++;
    if (bit_rdy_o !== 1'b1 || bit_code_o !== INV) begin
      errors++;
      $display("FAIL reset_first_edge rdy=%b exp=1 code=%b exp=%b", bit_rdy_o, bit_code_o, INV);
    end
  endtask

  task automatic test_single_zero();
    bit exp_c[6];
    bit exp_r[6];
    exp_c = '{1, 1, 0, 0, 0, 0};
    exp_r = '{0, 0, 0, 0, 1, 1};
    reg_t0h_time_i = 8'd2;
    reg_t0s_time_i = 9'd5;
    bit_data_i = 1'b0;
    bit_vld_i  = 1'b1;
    tick();
    bit_vld_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (bit_code_o !== (exp_c[k] ^ INV) || bit_rdy_o !== exp_r[k]) begin
        errors++;
        $display("FAIL single_zero cyc=n+%0d code=%b exp=%b rdy=%b exp=%b",
                 k + 1, bit_code_o, exp_c[k] ^ INV, bit_rdy_o, exp_r[k]);
      end
      checks++;
      if (bit_code_o !== m_code() || bit_rdy_o !== m_rdy()) begin
        errors++;
        $display("FAIL single_zero_model cyc=%0d code=%b exp=%b", k, bit_code_o, m_code());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int dut_acc;
    reg_t1h_time_i = 8'd4;
    reg_t1s_time_i = 9'd8;
    bit_data_i = 1'b1;
    bit_vld_i  = 1'b1;
    tick();
    dut_acc = 1;
    for (int i = 0; i < 24; i++) begin
      checks++;
      if (bit_code_o !== (((i % 8) < 4) ^ INV) || bit_rdy_o !== m_rdy()) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d code=%b exp=%b rdy=%b exp=%b",
                 i, bit_code_o, ((i % 8) < 4) ^ INV, bit_rdy_o, m_rdy());
      end
      if (bit_vld_i && bit_rdy_o) dut_acc++;
      tick();
      if (dut_acc == 3) bit_vld_i = 1'b0;
    end
    checks++;
    if (dut_acc != 3 || bit_code_o !== INV || bit_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_end accepts=%0d exp=3 code=%b rdy=%b", dut_acc, bit_code_o, bit_rdy_o);
    end
  endtask

  task automatic test_boundary();
    int t_data[5] = '{1, 0, 0, 1, 1};
    int t_h[5]    = '{10, 0, 0, 200, 10};
    int t_s[5]    = '{6, 3, 0, 0, 6};
    int t_n[5]    = '{1, 1, 1, 1, 2};
    int t_hi[5]   = '{6, 0, 0, 1, 12};
    int t_len[5]  = '{6, 3, 1, 1, 12};
    int highs, accs;
    for (int e = 0; e < 5; e++) begin
      bit_data_i     = t_data[e][0];
      reg_t1h_time_i = 8'(t_h[e]);
      reg_t0h_time_i = 8'(t_h[e]);
      reg_t1s_time_i = 9'(t_s[e]);
      reg_t0s_time_i = 9'(t_s[e]);
      bit_vld_i = 1'b1;
      highs = 0;
      accs  = 0;
      for (int c = 0; c < t_len[e] + 2; c++) begin
        checks++;
        if (bit_code_o !== m_code() || bit_rdy_o !== m_rdy()) begin
          errors++;
          $display("FAIL boundary%0d cyc=%0d code=%b exp=%b rdy=%b exp=%b",
                   e, c, bit_code_o, m_code(), bit_rdy_o, m_rdy());
        end
        if ((bit_code_o ^ INV) === 1'b1) highs++;
        if (bit_vld_i && bit_rdy_o) accs++;
        tick();
        if (accs >= t_n[e]) bit_vld_i = 1'b0;
      end
      checks++;
      if (highs != t_hi[e]) begin
        errors++;
        $display("FAIL boundary%0d_high_cycles got=%0d exp=%0d", e, highs, t_hi[e]);
      end
    end
  endtask

  task automatic test_reg_change();
    int highs[2];
    int idx;
    reg_t0h_time_i = 8'd2;
    reg_t0s_time_i = 9'd9;
    bit_data_i = 1'b0;
    bit_vld_i  = 1'b1;
    tick();
    highs = '{0, 0};
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 1) reg_t0h_time_i = 8'd7;
      checks++;
      if (bit_code_o !== m_code() || bit_rdy_o !== m_rdy()) begin
        errors++;
        $display("FAIL reg_change cyc=%0d code=%b exp=%b rdy=%b exp=%b",
                 c, bit_code_o, m_code(), bit_rdy_o, m_rdy());
      end
      if ((bit_code_o ^ INV) === 1'b1 && idx < 2) highs[idx]++;
      if (bit_vld_i && bit_rdy_o) begin
        idx++;
        if (idx == 1) begin
          tick();
          bit_vld_i = 1'b0;
          continue;
        end
      end
      tick();
    end
    checks++;
    if (highs[0] != 2 || highs[1] != 7) begin
      errors++;
      $display("FAIL reg_change_highs got=%0d,%0d exp=2,7", highs[0], highs[1]);
    end
  endtask

  task automatic test_reset_mid_bit();
    reg_t1h_time_i = 8'd5;
    reg_t1s_time_i = 9'd8;
    bit_data_i = 1'b1;
    bit_vld_i  = 1'b1;
    tick();
    bit_vld_i = 1'b0;
    tick();
    #2;
    rst_i = 1'b1;
    q.delete();
    started = 1'b0;
    #1;
    checks++;
    if (bit_code_o !== INV || bit_rdy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_bit code=%b exp=%b rdy=%b exp=0", bit_code_o, INV, bit_rdy_o);
    end
    tick();
    rst_i = 1'b0;
    tick();
    checks++;
    if (bit_rdy_o !== 1'b1 || bit_code_o !== INV) begin
      errors++;
      $display("FAIL reset_mid_bit_recover rdy=%b exp=1 code=%b", bit_rdy_o, bit_code_o);
    end
    bit_vld_i = 1'b1;
    tick();
    bit_vld_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bit_code_o !== m_code() || bit_rdy_o !== m_rdy()) begin
        errors++;
        $display("FAIL reset_mid_bit_next cyc=%0d code=%b exp=%b rdy=%b exp=%b",
                 c, bit_code_o, m_code(), bit_rdy_o, m_rdy());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      checks++;
      if (bit_code_o !== m_code() || bit_rdy_o !== m_rdy()) begin
        errors++;
        $display("FAIL random cyc=%0d code=%b exp=%b rdy=%b exp=%b",
                 c, bit_code_o, m_code(), bit_rdy_o, m_rdy());
      end
      bit_vld_i  = ($urandom_range(0, 9) < 7);
      bit_data_i = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        reg_t0h_time_i = 8'($urandom_range(0, 12));
        reg_t0s_time_i = 9'($urandom_range(0, 12));
        reg_t1h_time_i = 8'($urandom_range(0, 12));
        reg_t1s_time_i = 9'($urandom_range(0, 12));
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_back_to_back();
    test_boundary();
    test_reg_change();
    test_reset_mid_bit();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
